// File: rtl/snake_pkg.sv
// Shared constants, direction/state encodings and helpers for the snake game engine.
package snake_pkg;

   localparam int unsigned BODY_SLOTS  = 16;
   localparam int unsigned CELL_BITS   = 10;
   localparam int unsigned SCORE_BITS  = 4;
   localparam int unsigned GRID_WIDTH  = 32;
   localparam int unsigned GRID_HEIGHT = 24;
   localparam int unsigned START_LEN   = 3;
   localparam int unsigned START_POS   = 170;

   localparam logic [CELL_BITS-1:0] EMPTY_CELL = CELL_BITS'(10'h3FF);

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_COMMIT,
      ST_DEAD
   } state_e;

   // Opposite directions differ only in bit 0.
   function automatic logic is_reversal(dir_e cur, dir_e req);
      return (cur ^ req) == 2'b01;
   endfunction

endpackage

// File: rtl/snake_if.sv
// Control/status bundle between the game top level and one snake engine.
interface snake_if import snake_pkg::*; #(
   parameter int unsigned MAX_LEN  = BODY_SLOTS,
   parameter int unsigned NUM_LEN  = CELL_BITS,
   parameter int unsigned LEN_BITS = SCORE_BITS
);
   logic                        start;
   logic                        step;
   logic [1:0]                  dir_in;
   logic [NUM_LEN-1:0]          food1;
   logic [NUM_LEN-1:0]          food2;
   logic [MAX_LEN*NUM_LEN-1:0]  other_snake;
   logic [LEN_BITS-1:0]         other_len;
   logic [MAX_LEN*NUM_LEN-1:0]  snake;
   logic [LEN_BITS-1:0]         score;
   logic                        ate;
   logic                        dead;
   logic                        done;
   logic                        busy;

   modport master (
      output start, step, dir_in, food1, food2, other_snake, other_len,
      input  snake, score, ate, dead, done, busy
   );

   modport slave (
      input  start, step, dir_in, food1, food2, other_snake, other_len,
      output snake, score, ate, dead, done, busy
   );
endinterface

// File: rtl/snake_next_head.sv
// Neighbouring cell in a given direction plus a flag when that move would leave the grid.
module snake_next_head import snake_pkg::*; #(
   parameter int unsigned NUM_LEN = CELL_BITS,
   parameter int unsigned WIDTH   = GRID_WIDTH,
   parameter int unsigned HEIGHT  = GRID_HEIGHT
) (
   input  logic [NUM_LEN-1:0] cell_i,
   input  dir_e               dir_i,
   output logic [NUM_LEN-1:0] next_cell_c_o,
   output logic               wall_c_o
);
   logic [NUM_LEN-1:0] row;
   logic [NUM_LEN-1:0] col;

   assign row = cell_i / NUM_LEN'(WIDTH);
   assign col = cell_i % NUM_LEN'(WIDTH);

   // Wall is judged on row/col; the cell arithmetic itself may wrap harmlessly.
   always_comb begin
      next_cell_c_o = cell_i;
      wall_c_o      = 1'b0;
      unique case (dir_i)
         DIR_UP: begin
            wall_c_o      = (row == '0);
            next_cell_c_o = cell_i - NUM_LEN'(WIDTH);
         end
         DIR_DOWN: begin
            wall_c_o      = (row == NUM_LEN'(HEIGHT - 1));
            next_cell_c_o = cell_i + NUM_LEN'(WIDTH);
         end
         DIR_LEFT: begin
            wall_c_o      = (col == '0);
            next_cell_c_o = cell_i - NUM_LEN'(1);
         end
         DIR_RIGHT: begin
            wall_c_o      = (col == NUM_LEN'(WIDTH - 1));
            next_cell_c_o = cell_i + NUM_LEN'(1);
         end
      endcase
   end
endmodule

// File: rtl/snake_engine.sv
// One snake's body/length/direction state with a one-slot-per-cycle collision scan.
module snake_engine import snake_pkg::*; #(
   parameter int unsigned MAX_LEN  = BODY_SLOTS,
   parameter int unsigned NUM_LEN  = CELL_BITS,
   parameter int unsigned LEN_BITS = SCORE_BITS,
   parameter int unsigned WIDTH    = GRID_WIDTH,
   parameter int unsigned HEIGHT   = GRID_HEIGHT,
   parameter int unsigned INIT_LEN = START_LEN,
   parameter int unsigned INIT_POS = START_POS
) (
   input  logic    clk,
   input  logic    rst,
   snake_if.slave  eng_if
);
   localparam int unsigned        K_BITS    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [NUM_LEN-1:0] EMPTY     = '1;
   localparam logic [LEN_BITS-1:0] SCORE_MAX = LEN_BITS'(MAX_LEN - 1);

   state_e              state_q;
   dir_e                dir_q;
   dir_e                dir_d;
   logic [NUM_LEN-1:0]  body_q [MAX_LEN];
   logic [LEN_BITS-1:0] score_q;
   logic [LEN_BITS-1:0] score_d;
   logic [NUM_LEN-1:0]  head_q;
   logic                wall_q;
   logic                grow_q;
   logic                hit_q;
   logic [K_BITS-1:0]   k_q;
   logic                ate_q;
   logic                done_q;
   logic                dead_q;
   logic                busy_q;

   logic [NUM_LEN-1:0]  nh_c;
   logic                wall_c;
   logic [NUM_LEN-1:0]  other_cell_c;
   logic                own_hit_c;
   logic                other_hit_c;

   assign dir_d = is_reversal(dir_q, dir_e'(eng_if.dir_in)) ? dir_q : dir_e'(eng_if.dir_in);

   snake_next_head #(
      .NUM_LEN (NUM_LEN),
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT)
   ) u_next_head (
      .cell_i        (body_q[0]),
      .dir_i         (dir_d),
      .next_cell_c_o (nh_c),
      .wall_c_o      (wall_c)
   );

   // The tail slot is about to vacate unless the snake grows, so it is not an obstacle.
   assign other_cell_c = eng_if.other_snake[32'(k_q)*NUM_LEN +: NUM_LEN];
   assign own_hit_c    = (32'(k_q) < 32'(score_q)) && (body_q[k_q] == head_q) &&
                         !((32'(k_q) + 32'd1 == 32'(score_q)) && !grow_q);
   assign other_hit_c  = (32'(k_q) < 32'(eng_if.other_len)) && (other_cell_c == head_q);
   assign score_d      = (grow_q && (score_q != SCORE_MAX)) ? score_q + LEN_BITS'(1) : score_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) body_q[i] <= EMPTY;
         state_q <= ST_IDLE;
         dir_q   <= DIR_RIGHT;
         score_q <= '0;
         head_q  <= '0;
         wall_q  <= 1'b0;
         grow_q  <= 1'b0;
         hit_q   <= 1'b0;
         k_q     <= '0;
         ate_q   <= 1'b0;
         done_q  <= 1'b0;
         dead_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ate_q  <= 1'b0;
         done_q <= 1'b0;
         if (eng_if.start) begin
            for (int unsigned i = 0; i < MAX_LEN; i++)
               body_q[i] <= (i < INIT_LEN) ? NUM_LEN'(INIT_POS - i) : EMPTY;
            score_q <= LEN_BITS'(INIT_LEN);
            dir_q   <= DIR_RIGHT;
            dead_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (eng_if.step && (score_q != '0)) begin
                     dir_q   <= dir_d;
                     head_q  <= nh_c;
                     wall_q  <= wall_c;
                     grow_q  <= (nh_c == eng_if.food1) || (nh_c == eng_if.food2);
                     hit_q   <= 1'b0;
                     k_q     <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  if (own_hit_c || other_hit_c) hit_q <= 1'b1;
                  k_q <= k_q + K_BITS'(1);
                  if (k_q == K_BITS'(MAX_LEN - 1)) state_q <= ST_COMMIT;
               end
               ST_COMMIT: begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  if (wall_q || hit_q) begin
                     dead_q  <= 1'b1;
                     state_q <= ST_DEAD;
                  end else begin
                     body_q[0] <= head_q;
                     for (int unsigned i = 1; i < MAX_LEN; i++)
                        body_q[i] <= (i < 32'(score_d)) ? body_q[i-1] : EMPTY;
                     score_q <= score_d;
                     ate_q   <= grow_q;
                     state_q <= ST_IDLE;
                  end
               end
               ST_DEAD: begin
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_slot
      assign eng_if.snake[g*NUM_LEN +: NUM_LEN] = body_q[g];
   end

   assign eng_if.score = score_q;
   assign eng_if.ate   = ate_q;
   assign eng_if.done  = done_q;
   assign eng_if.dead  = dead_q;
   assign eng_if.busy  = busy_q;
endmodule
